bsg_dll_cal_ctrl: RTL

BSG_DLL_CAL_CTRL -- requirements
Module: bsg_dll_cal_ctrl

---
 rtl/bsg_chip_pkg.sv | 38 +++
 rtl/bsg_dll_cal_ctrl_if.sv | 41 ++++
 rtl/bsg_dll_cal_timer.sv | 38 +++
 rtl/bsg_dll_cal_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bsg_chip_pkg.sv
// ============================================================================
// bsg_chip_pkg : chip-level delay-line parameters and DLL calibration types
// Revision     : 1.0
// ============================================================================
`default_nettype none

package bsg_chip_pkg;

   localparam int dly_code_width_gp         = 4;
   localparam int div_count_width_gp        = 8;

   localparam int dly_cal_settle_cycles_gp  = 16;
   localparam int dly_cal_timeout_cycles_gp = 255;
   localparam int dly_cal_max_rev_gp        = 2;

   typedef enum logic [2:0] {
      CAL_IDLE   = 3'd0,
      CAL_SETTLE = 3'd1,
      CAL_REQ    = 3'd2,
      CAL_WAIT   = 3'd3,
      CAL_EVAL   = 3'd4,
      CAL_LOCKED = 3'd5,
      CAL_ERROR  = 3'd6
   } bsg_dll_cal_state_e;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } bsg_dll_cal_dir_e;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_dll_cal_ctrl_if.sv
// ============================================================================
// bsg_dll_cal_ctrl_if : control, measurement and status bundle of the DLL
//                       calibration controller
// Revision            : 1.0
// ============================================================================
`default_nettype none

interface bsg_dll_cal_ctrl_if
   import bsg_chip_pkg::*;
#(
   parameter int code_width_p  = dly_code_width_gp,
   parameter int count_width_p = div_count_width_gp
);

   logic                     start_i;
   logic                     abort_i;
   logic [count_width_p-1:0] target_i;
   logic [count_width_p-1:0] tol_i;
   logic                     meas_req_o;
   logic                     meas_v_i;
   logic [count_width_p-1:0] meas_count_i;
   logic [code_width_p-1:0]  dly_code_o;
   logic                     busy_o;
   logic                     locked_o;
   logic                     err_o;

   // Controller side
   modport slave (
      input  start_i, abort_i, target_i, tol_i, meas_v_i, meas_count_i,
      output meas_req_o, dly_code_o, busy_o, locked_o, err_o
   );

   // Host / period-counter side
   modport master (
      output start_i, abort_i, target_i, tol_i, meas_v_i, meas_count_i,
      input  meas_req_o, dly_code_o, busy_o, locked_o, err_o
   );

endinterface

`default_nettype wire

// File: rtl/bsg_dll_cal_timer.sv
// ============================================================================
// bsg_dll_cal_timer : loadable down-counter that stops at zero, with zero flag
// Revision          : 1.0
// ============================================================================
`default_nettype none

module bsg_dll_cal_timer #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               load_i,
   input  logic [width_p-1:0] load_val_i,
   output logic               zero_o
);

   logic [width_p-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i)
         count_d = load_val_i;
      else if (count_q != '0)
         count_d = count_q - width_p'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/bsg_dll_cal_ctrl.sv
// ============================================================================
// bsg_dll_cal_ctrl : steps a delay-line tap code until the measured period
//                    count falls inside target +/- tolerance
// Revision         : 1.0
// ============================================================================
`default_nettype none

module bsg_dll_cal_ctrl
   import bsg_chip_pkg::*;
#(
   parameter int code_width_p     = dly_code_width_gp,
   parameter int count_width_p    = div_count_width_gp,
   parameter int settle_cycles_p  = dly_cal_settle_cycles_gp,
   parameter int timeout_cycles_p = dly_cal_timeout_cycles_gp,
   parameter int max_rev_p        = dly_cal_max_rev_gp
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   bsg_dll_cal_ctrl_if.slave  bus
);

   localparam int timer_width_lp = $clog2(max2(settle_cycles_p, timeout_cycles_p) + 1);
   localparam int rev_width_lp   = $clog2(max_rev_p + 1);

   localparam logic [code_width_p-1:0]   code_mid_lp    = {1'b1, {(code_width_p-1){1'b0}}};
   localparam logic [code_width_p-1:0]   code_max_lp    = '1;
   localparam logic [count_width_p:0]    count_max_lp   = {1'b0, {count_width_p{1'b1}}};
   localparam logic [rev_width_lp-1:0]   rev_limit_lp   = rev_width_lp'(max_rev_p);
   // Timer counts down to zero inclusive: SETTLE spans load+1 cycles, and the
   // REQ cycle itself is the first of the timeout window.
   localparam logic [timer_width_lp-1:0] settle_load_lp  = timer_width_lp'(settle_cycles_p - 1);
   localparam logic [timer_width_lp-1:0] timeout_load_lp = timer_width_lp'(timeout_cycles_p - 2);

   bsg_dll_cal_state_e         state_q, state_d;
   bsg_dll_cal_dir_e           dir_q, dir_d;
   logic [code_width_p-1:0]    code_q, code_d;
   logic [rev_width_lp-1:0]    rev_q, rev_d;
   logic [count_width_p-1:0]   count_q, count_d;

   logic                       timer_load;
   logic [timer_width_lp-1:0]  timer_val;
   logic                       timer_zero;

   logic [count_width_p:0]     diff, sum, lo, hi, count_ext;
   logic                       go_up, go_dn, reversal;
   logic [rev_width_lp-1:0]    rev_inc;

   bsg_dll_cal_timer #(
      .width_p   (timer_width_lp)
   ) u_timer (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .load_i     (timer_load),
      .load_val_i (timer_val),
      .zero_o     (timer_zero)
   );

   // Band edges at one extra bit so the saturation is visible as carry/borrow
   assign diff      = {1'b0, bus.target_i} - {1'b0, bus.tol_i};
   assign sum       = {1'b0, bus.target_i} + {1'b0, bus.tol_i};
   assign lo        = diff[count_width_p] ? '0 : diff;
   assign hi        = sum[count_width_p] ? count_max_lp : sum;
   assign count_ext = {1'b0, count_q};
   assign go_up     = (count_ext < lo);
   assign go_dn     = (count_ext > hi);
   assign reversal  = ((dir_q == DIR_UP) && go_dn) || ((dir_q == DIR_DN) && go_up);
   assign rev_inc   = rev_q + rev_width_lp'(1);

   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      code_d     = code_q;
      rev_d      = rev_q;
      count_d    = count_q;
      timer_load = 1'b0;
      timer_val  = settle_load_lp;

      case (state_q)
         CAL_IDLE, CAL_LOCKED, CAL_ERROR: begin
            if (bus.start_i) begin
               state_d    = CAL_SETTLE;
               code_d     = code_mid_lp;
               dir_d      = DIR_NONE;
               rev_d      = '0;
               timer_load = 1'b1;
            end
         end
         CAL_SETTLE: begin
            if (timer_zero)
               state_d = CAL_REQ;
         end
         CAL_REQ: begin
            state_d    = CAL_WAIT;
            timer_load = 1'b1;
            timer_val  = timeout_load_lp;
         end
         CAL_WAIT: begin
            if (bus.meas_v_i) begin
               count_d = bus.meas_count_i;
               state_d = CAL_EVAL;
            end else if (timer_zero) begin
               state_d = CAL_ERROR;
            end
         end
         CAL_EVAL: begin
            if (!go_up && !go_dn) begin
               state_d = CAL_LOCKED;
            end else if ((go_up && (code_q == code_max_lp)) || (go_dn && (code_q == '0))) begin
               state_d = CAL_ERROR;
            end else if (reversal && (rev_inc == rev_limit_lp)) begin
               rev_d   = rev_inc;
               state_d = CAL_LOCKED;
            end else begin
               if (reversal)
                  rev_d = rev_inc;
               code_d     = go_up ? code_q + code_width_p'(1) : code_q - code_width_p'(1);
               dir_d      = go_up ? DIR_UP : DIR_DN;
               state_d    = CAL_SETTLE;
               timer_load = 1'b1;
            end
         end
         default: state_d = CAL_IDLE;
      endcase

      if (bus.abort_i) begin
         state_d    = CAL_IDLE;
         code_d     = code_q;
         timer_load = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= CAL_IDLE;
         dir_q   <= DIR_NONE;
         code_q  <= '0;
         rev_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         code_q  <= code_d;
         rev_q   <= rev_d;
         count_q <= count_d;
      end
   end

   assign bus.meas_req_o = (state_q == CAL_REQ);
   assign bus.busy_o     = (state_q == CAL_SETTLE) || (state_q == CAL_REQ) ||
                           (state_q == CAL_WAIT)   || (state_q == CAL_EVAL);
   assign bus.locked_o   = (state_q == CAL_LOCKED);
   assign bus.err_o      = (state_q == CAL_ERROR);
   assign bus.dly_code_o = code_q;

endmodule

`default_nettype wire
